acq_sequencer: RTL
==================

// Module: acq_sequencer
// PURPOSE
//  Parametrised multi-channel acquisition sequencer, next generation of the measurement FSM.
//  On each generator period-start pulse it walks NUM_CH channels. Per channel it:
//   - writes a mode byte to the range/mode register over SPI,
//   - drives the analog mux, waits for settling, converts, reads the ADC over SPI,
//   - emits one tagged sample.
//  Sits between sin_gen (period strobe) and the downstream sample FIFO/packetiser.
// PARAMETERS
//  NUM_CH      6    channels per frame (ch0 = range/diapason, ch1..5 = modes); 1..8
//  CH_W        3    width of mux/channel index; must satisfy 2**CH_W >= NUM_CH
//  ADC_W       16   ADC result width (bits clocked in, MSB first)
//  MODE_W      8    register word per channel (bits shifted out, MSB first)
//  SCK_DIV     4    clk cycles per SPI half-period; >=1
//  SETTLE_CYC  64   clk cycles from mux/register update to adc_cnv
//  BUSY_TMO    1024 clk cycles allowed for adc_busy to fall
// PORTS
//  clk          in   1               system clock
//  rst          in   1               synchronous, active-high reset
//  enable       in   1               frame start permitted; low aborts at next channel boundary
//  start        in   1               period-start strobe (1 clk) from sin_gen
//  mode_words   in   NUM_CH*MODE_W   per-channel register word, ch0 in LSBs; sampled at frame start
//  reg_sck      out  1               register/DAC SPI clock, idle low
//  reg_mosi     out  1               register/DAC SPI data
//  cs_reg       out  1               register chip select, active low
//  adc_cnv      out  1               convert strobe, high 2 clk
//  adc_busy     in   1               ADC conversion in progress
//  adc_sck      out  1               ADC SPI clock, idle low
//  adc_miso     in   1               ADC SPI data, sampled on adc_sck rising edge
//  mux_chn      out  CH_W            analog mux select
//  sample_vld   out  1               1-clk pulse, sample fields valid
//  sample_data  out  ADC_W           conversion result
//  sample_chn   out  CH_W            channel tag of sample
//  sample_err   out  1               busy timeout on this sample (sample_data = 0)
//  frame_done   out  1               1-clk pulse after last channel of a completed frame
//  busy_o       out  1               high from accepted start to IDLE
// BEHAVIOUR
//  Reset: state IDLE; all strobes 0; cs_reg=1; sck/mosi=0; mux_chn=0; sample_* =0; busy_o=0.
//  States:
//   IDLE      -> REG_WR when start & enable; latch mode_words; ch=0.
//   REG_WR    -> SETTLE when MODE_W bits are shifted. mux_chn=ch is driven on entry.
//   SETTLE    -> CONVERT after SETTLE_CYC cycles.
//   CONVERT   -> WAIT_BUSY; adc_cnv high for 2 cycles.
//   WAIT_BUSY -> READ when adc_busy is low, checked from the 3rd cycle on.
//             -> EMIT with err=1 once BUSY_TMO is reached.
//   READ      -> EMIT after ADC_W bits are clocked in.
//   EMIT      sample_vld=1 for 1 cycle.
//             -> IDLE + frame_done if ch==NUM_CH-1.
//             -> IDLE with no frame_done if !enable.
//             -> otherwise REG_WR with ch+1.
//  start while busy_o=1: ignored, not queued. start & !enable in IDLE: ignored.
//  cs_reg is low only during REG_WR. The SPI frame obeys SCK_DIV; cs setup/hold = SCK_DIV clk.
//  Channel index wraps never; the frame ends at NUM_CH-1.
//  Reset mid-frame: immediate return to reset values; a partial sample is never emitted.
// CONFIGURATION
//  ACQ_OVERSAMPLE_EN defined:
//   - parameter OVS_LOG2 (default 2) takes effect.
//   - Each channel loops CONVERT..READ 2**OVS_LOG2 times after one REG_WR/SETTLE.
//   - Results accumulate in an ADC_W+OVS_LOG2 register; sample_data = sum >> OVS_LOG2 (truncate).
//   - Any timeout in the loop sets sample_err and forces sample_data=0.
//  Undefined: one conversion per channel; no accumulator is synthesised.
// STRUCTURE
//  acq_pkg: state enum, default widths, CNV_PULSE=2.
//  Sub-module acq_spi_shift: one parametrised shift engine, instanced twice:
//   - tx-only for the register port,
//   - rx-only for the ADC port.
//  acq_spi_shift interface: start, bit count, SCK_DIV, done pulse.
// TESTING
//  1 NUM_CH=6, mode_words=0x060504030201, ADC model returns 0x1000+ch, start pulse:
//    six samples, chn 0..5, data 0x1000..0x1005, then one frame_done; reg_mosi bytes 01..06.
//  2 start re-pulsed mid-frame:
//    no extra samples; the next start after IDLE begins a new frame.
//  3 adc_busy stuck high on ch2:
//    sample_err=1, data=0 after BUSY_TMO; frame continues to ch5.
//  4 enable dropped during ch3 SETTLE:
//    ch3 is emitted, no ch4, no frame_done, busy_o falls.
//  5 rst asserted during ch1 READ:
//    all outputs at reset values next clk; no sample_vld.
//  6 ACQ_OVERSAMPLE_EN, OVS_LOG2=2, ADC returns 10,11,12,13:
//    a single sample with data=11.

Source files
------------

// File: rtl/acq_pkg.sv
// Shared types and constants for the acquisition sequencer and its SPI shift engine.
package acq_pkg;
    typedef enum logic [2:0] {
        S_IDLE, S_REG_WR, S_SETTLE, S_CONVERT, S_WAIT_BUSY, S_READ, S_EMIT
    } acq_state_t;

    typedef enum logic [2:0] {P_IDLE, P_SETUP, P_LOW, P_HIGH, P_HOLD} spi_ph_t;

    localparam int CNV_PULSE    = 2;
    localparam int BUSY_GUARD   = 2;  // adc_busy not trusted for the first cycles after cnv
    localparam int DEF_NUM_CH   = 6;
    localparam int DEF_CH_W     = 3;
    localparam int DEF_ADC_W    = 16;
    localparam int DEF_MODE_W   = 8;
    localparam int DEF_SCK_DIV  = 4;
    localparam int DEF_SETTLE   = 64;
    localparam int DEF_BUSY_TMO = 1024;

    function automatic int cnt_bits(input int a, input int b);
        return $clog2((a > b ? a : b) + 1);
    endfunction
endpackage

// File: rtl/acq_spi_shift.sv
// Mode-0 SPI shift engine (MSB first): cs setup, nbits clocks, cs hold, then a done pulse.
module acq_spi_shift
    import acq_pkg::*;
#(
    parameter int W       = 8,
    parameter int SCK_DIV = 4,
    localparam int NB_W   = $clog2(W + 1),
    localparam int DV_W   = $clog2(SCK_DIV) + 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [NB_W-1:0] nbits,
    input  logic [W-1:0]    tx_data,
    input  logic            miso,
    output logic            sck,
    output logic            mosi,
    output logic            cs_n,
    output logic            done,
    output logic [W-1:0]    rx_data
);
    spi_ph_t         ph;
    logic [DV_W-1:0] div_cnt;
    logic [NB_W-1:0] bit_cnt;
    logic [W-1:0]    sr;
    logic            half_end;

    assign half_end = (div_cnt == DV_W'(SCK_DIV - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            ph      <= P_IDLE;
            div_cnt <= '0;
            bit_cnt <= '0;
            sr      <= '0;
            rx_data <= '0;
            sck     <= 1'b0;
            mosi    <= 1'b0;
            cs_n    <= 1'b1;
            done    <= 1'b0;
        end else begin
            done    <= 1'b0;
            div_cnt <= half_end ? '0 : div_cnt + 1'b1;
            case (ph)
                P_IDLE: begin
                    div_cnt <= '0;
                    if (start) begin
                        ph      <= P_SETUP;
                        cs_n    <= 1'b0;
                        sr      <= tx_data;
                        bit_cnt <= '0;
                    end
                end
                P_SETUP: if (half_end) begin
                    ph   <= P_LOW;
                    mosi <= sr[W-1];
                end
                P_LOW: if (half_end) begin
                    ph      <= P_HIGH;
                    sck     <= 1'b1;
                    rx_data <= {rx_data[W-2:0], miso};
                end
                P_HIGH: if (half_end) begin
                    sck     <= 1'b0;
                    sr      <= {sr[W-2:0], 1'b0};
                    bit_cnt <= bit_cnt + 1'b1;
                    if (bit_cnt == nbits - 1'b1) begin
                        ph   <= P_HOLD;
                        mosi <= 1'b0;
                    end else begin
                        ph   <= P_LOW;
                        mosi <= sr[W-2];
                    end
                end
                P_HOLD: if (half_end) begin
                    ph   <= P_IDLE;
                    cs_n <= 1'b1;
                    done <= 1'b1;
                end
                default: ph <= P_IDLE;
            endcase
        end
    end
endmodule

// File: rtl/acq_sequencer.sv
// Multi-channel acquisition sequencer: per channel register write, settle, convert, ADC read, emit.
// Optional ACQ_OVERSAMPLE_EN averages 2**OVS_LOG2 conversions per channel.
module acq_sequencer
    import acq_pkg::*;
#(
    parameter int NUM_CH     = DEF_NUM_CH,
    parameter int CH_W       = DEF_CH_W,
    parameter int ADC_W      = DEF_ADC_W,
    parameter int MODE_W     = DEF_MODE_W,
    parameter int SCK_DIV    = DEF_SCK_DIV,
    parameter int SETTLE_CYC = DEF_SETTLE,
    parameter int BUSY_TMO   = DEF_BUSY_TMO
`ifdef ACQ_OVERSAMPLE_EN
    , parameter int OVS_LOG2 = 2
`endif
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     enable,
    input  logic                     start,
    input  logic [NUM_CH*MODE_W-1:0] mode_words,
    output logic                     reg_sck,
    output logic                     reg_mosi,
    output logic                     cs_reg,
    output logic                     adc_cnv,
    input  logic                     adc_busy,
    output logic                     adc_sck,
    input  logic                     adc_miso,
    output logic [CH_W-1:0]          mux_chn,
    output logic                     sample_vld,
    output logic [ADC_W-1:0]         sample_data,
    output logic [CH_W-1:0]          sample_chn,
    output logic                     sample_err,
    output logic                     frame_done,
    output logic                     busy_o
);
    localparam int CNT_W  = cnt_bits(SETTLE_CYC, BUSY_TMO);
    localparam int NB_REG = $clog2(MODE_W + 1);
    localparam int NB_ADC = $clog2(ADC_W + 1);

    acq_state_t                   state, state_n;
    logic [CH_W-1:0]              ch;
    logic [NUM_CH-1:0][MODE_W-1:0] modes_q;
    logic [CNT_W-1:0]             cnt;
    logic                         reg_go, reg_start, reg_done;
    logic                         adc_go, adc_start, adc_done;
    logic                         tmo, last_ch, ovs_more;
    logic [ADC_W-1:0]             adc_rx, result;
    logic [MODE_W-1:0]            reg_rx_unused;
    logic                         adc_mosi_unused, adc_cs_unused;

    assign last_ch = (ch == CH_W'(NUM_CH - 1));
    assign adc_cnv = (state == S_CONVERT);
    assign busy_o  = (state != S_IDLE);

`ifdef ACQ_OVERSAMPLE_EN
    logic [OVS_LOG2-1:0]       ovs_cnt;
    logic [ADC_W+OVS_LOG2-1:0] acc, acc_n;

    assign acc_n    = acc + (ADC_W + OVS_LOG2)'(adc_rx);
    assign ovs_more = (ovs_cnt != {OVS_LOG2{1'b1}});
    assign result   = acc_n[ADC_W+OVS_LOG2-1:OVS_LOG2];

    // Every channel passes through SETTLE once before its conversion loop.
    always_ff @(posedge clk) begin
        if (rst || state == S_SETTLE) begin
            ovs_cnt <= '0;
            acc     <= '0;
        end else if (state == S_READ && adc_done) begin
            ovs_cnt <= ovs_cnt + 1'b1;
            acc     <= acc_n;
        end
    end
`else
    assign ovs_more = 1'b0;
    assign result   = adc_rx;
`endif

    always_ff @(posedge clk) begin
        if (rst) state <= S_IDLE;
        else     state <= state_n;
    end

    always_comb begin
        state_n = state;
        reg_go  = 1'b0;
        adc_go  = 1'b0;
        tmo     = 1'b0;
        case (state)
            S_IDLE: if (start && enable) begin
                state_n = S_REG_WR;
                reg_go  = 1'b1;
            end
            S_REG_WR:  if (reg_done) state_n = S_SETTLE;
            S_SETTLE:  if (cnt == CNT_W'(SETTLE_CYC - 1)) state_n = S_CONVERT;
            S_CONVERT: if (cnt == CNT_W'(CNV_PULSE - 1)) state_n = S_WAIT_BUSY;
            S_WAIT_BUSY: begin
                if (cnt >= CNT_W'(BUSY_GUARD) && !adc_busy) begin
                    state_n = S_READ;
                    adc_go  = 1'b1;
                end else if (cnt == CNT_W'(BUSY_TMO - 1)) begin
                    state_n = S_EMIT;
                    tmo     = 1'b1;
                end
            end
            S_READ: if (adc_done) state_n = ovs_more ? S_CONVERT : S_EMIT;
            S_EMIT: begin
                if (!last_ch && enable) begin
                    state_n = S_REG_WR;
                    reg_go  = 1'b1;
                end else begin
                    state_n = S_IDLE;
                end
            end
            default: state_n = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ch          <= '0;
            modes_q     <= '0;
            cnt         <= '0;
            reg_start   <= 1'b0;
            adc_start   <= 1'b0;
            mux_chn     <= '0;
            sample_vld  <= 1'b0;
            sample_data <= '0;
            sample_chn  <= '0;
            sample_err  <= 1'b0;
            frame_done  <= 1'b0;
        end else begin
            reg_start  <= reg_go;
            adc_start  <= adc_go;
            cnt        <= (state_n != state) ? '0 : cnt + 1'b1;
            sample_vld <= (state_n == S_EMIT);
            frame_done <= (state == S_EMIT) && last_ch;
            if (state == S_IDLE && reg_go) begin
                modes_q <= mode_words;
                ch      <= '0;
                mux_chn <= '0;
            end else if (reg_go) begin
                ch      <= ch + 1'b1;
                mux_chn <= ch + 1'b1;
            end
            if (tmo) begin
                sample_data <= '0;
                sample_err  <= 1'b1;
                sample_chn  <= ch;
            end else if (state == S_READ && adc_done && !ovs_more) begin
                sample_data <= result;
                sample_err  <= 1'b0;
                sample_chn  <= ch;
            end
        end
    end

    // Engines start one cycle after the state change so ch/modes_q are already updated.
    acq_spi_shift #(.W(MODE_W), .SCK_DIV(SCK_DIV)) u_reg_spi (
        .clk     (clk),
        .rst     (rst),
        .start   (reg_start),
        .nbits   (NB_REG'(MODE_W)),
        .tx_data (modes_q[ch]),
        .miso    (1'b0),
        .sck     (reg_sck),
        .mosi    (reg_mosi),
        .cs_n    (cs_reg),
        .done    (reg_done),
        .rx_data (reg_rx_unused)
    );

    acq_spi_shift #(.W(ADC_W), .SCK_DIV(SCK_DIV)) u_adc_spi (
        .clk     (clk),
        .rst     (rst),
        .start   (adc_start),
        .nbits   (NB_ADC'(ADC_W)),
        .tx_data ('0),
        .miso    (adc_miso),
        .sck     (adc_sck),
        .mosi    (adc_mosi_unused),
        .cs_n    (adc_cs_unused),
        .done    (adc_done),
        .rx_data (adc_rx)
    );
endmodule
